binary_frame_packer: RTL and testbench



---
 rtl/binary_frame_packer.sv | 104 ++++++++++
 tb/tb_binary_frame_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/binary_frame_packer.sv
// Frame-store writer for the 1-bit filtered stream leaving the binary window buffer.
// Skips the buffer's fill latency, tracks raster position, packs pixels MSB-first into words.
module binary_frame_packer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LATENCY  = 3835,
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              frame_start,
  input  logic              pixel_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int NPIX    = H_ACTIVE * V_ACTIVE;
  localparam int PIX_W   = $clog2(NPIX);
  localparam int PRIME_W = $clog2(LATENCY + 1);
  localparam int BIT_W   = $clog2(WORD_W);

  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(NPIX - 1);
  // Pixel index being drained when pixel (0,0) of the next frame enters the buffer.
  localparam logic [PIX_W-1:0]   PIX_SYNC   = PIX_W'(NPIX - LATENCY);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(LATENCY - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t              state;
  logic [PRIME_W-1:0]  prime_cnt;
  logic [PIX_W-1:0]    pix;
  logic [BIT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic [WORD_W-2:0]   sreg;

  // NOTE: every register here is updated with non-blocking assignments so all
  // next-state values are computed from the same pre-edge snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prime_cnt  <= '0;
      pix        <= '0;
      bit_cnt    <= '0;
      word_idx   <= '0;
      sreg       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (clken) begin
        unique case (state)
          IDLE: begin
            if (frame_start) begin
              state     <= (LATENCY == 1) ? RUN : PRIME;
              prime_cnt <= PRIME_W'(1);
            end
          end
          PRIME: begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
            if (prime_cnt == PRIME_LAST) state <= RUN;
          end
          RUN: begin
            if (frame_start && pix != PIX_SYNC) begin
              // Misplaced frame start: drop the partial word and re-prime from here.
              sync_err  <= 1'b1;
              pix       <= '0;
              bit_cnt   <= '0;
              word_idx  <= '0;
              sreg      <= '0;
              prime_cnt <= PRIME_W'(1);
              state     <= (LATENCY == 1) ? RUN : PRIME;
            end else begin
              if (!frame_start && pix == PIX_SYNC) sync_err <= 1'b1;
              sreg <= {sreg[WORD_W-3:0], pixel_in};
              pix  <= (pix == PIX_LAST) ? '0 : pix + PIX_W'(1);
              if (bit_cnt == BIT_LAST) begin
                bit_cnt    <= '0;
                wr_en      <= 1'b1;
                wr_data    <= {sreg, pixel_in};
                wr_addr    <= word_idx;
                word_idx   <= (pix == PIX_LAST) ? '0 : word_idx + ADDR_W'(1);
                frame_done <= (pix == PIX_LAST);
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_binary_frame_packer.sv
// Scoreboard bench for binary_frame_packer on a tiny 8x4 frame with 13-enable latency.
// A position-from-frame-start reference predicts each write word.
module tb_binary_frame_packer;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int L    = 13;
  localparam int W    = 8;
  localparam int A    = 2;
  localparam int NPIX = H * V;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         clken = 1'b0;
  logic         frame_start = 1'b0;
  logic         pixel_in = 1'b0;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         frame_done;
  logic         sync_err;

  binary_frame_packer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .LATENCY(L), .WORD_W(W), .ADDR_W(A)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clken(clken), .frame_start(frame_start),
    .pixel_in(pixel_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
    logic         done;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  bit          m_active;
  int          m_since;
  bit          m_err;
  logic [W-1:0] m_acc;

  int cyc_cnt = 0;
  int last_wr_cyc = -1;
  bit gap_chk = 0;
  int gap_want = 0;

  logic [7:0] pat = 8'hB1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: the sampled pixel index follows from enables counted since the frame start.
  task automatic model_step(input bit fs, input bit px);
    int p;
    if (!m_active) begin
      if (fs) begin
        m_active = 1;
        m_since  = 1;
      end
      return;
    end
    m_since++;
    if (m_since <= L) return;
    p = (m_since - L - 1) % NPIX;
    if (fs && p != NPIX - L) begin
      m_err   = 1;
      m_since = 1;
      return;
    end
    if (!fs && p == NPIX - L) m_err = 1;
    m_acc = {m_acc[W-2:0], px};
    if (p % W == W - 1)
      exp_q.push_back('{addr: A'(p / W), data: m_acc, done: (p == NPIX - 1)});
  endtask

  task automatic cyc(input bit ce, input bit fs, input bit px);
    wr_t e;
    clken       = ce;
    frame_start = fs;
    pixel_in    = px;
    if (ce) model_step(fs, px);
    @(posedge clock);
    #1;
    cyc_cnt++;
    check("wr_en", {31'd0, wr_en}, {31'd0, exp_q.size() != 0});
    if (wr_en && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
      check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
      check("frame_done", {31'd0, frame_done}, {31'd0, e.done});
      if (gap_chk && last_wr_cyc >= 0) check("wr_gap", cyc_cnt - last_wr_cyc, gap_want);
      last_wr_cyc = cyc_cnt;
    end else if (!wr_en) begin
      check("frame_done_idle", {31'd0, frame_done}, 32'd0);
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    clken       = 1'b0;
    frame_start = 1'b0;
    pixel_in    = 1'b0;
    m_active    = 0;
    m_since     = 0;
    m_err       = 0;
    m_acc       = '0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n     = 1'b1;
    last_wr_cyc = -1;
  endtask

  initial begin
    do_reset();
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_sync_err", {31'd0, sync_err}, 32'd0);

    // All-ones stream: first word 0xFF at addr 0 after enable 21, nothing earlier.
    for (int e = 1; e <= 24; e++) cyc(1'b1, e == 1, 1'b1);

    // Three aligned frames, 0xB1 leading word, stray frame_start pulses with clken low.
    do_reset();
    for (int e = 1; e <= 96; e++) begin
      bit px;
      px = (e >= 14 && e <= 21) ? pat[7 - (e - 14)] : 1'($urandom_range(0, 1));
      if (e % 5 == 0) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, (e % NPIX) == 1, px);
    end
    check("aligned_sync_err", {31'd0, sync_err}, 32'd0);

    // Half-rate enables: same word sequence, writes 16 cycles apart.
    do_reset();
    gap_chk  = 1;
    gap_want = 16;
    for (int e = 1; e <= 50; e++) begin
      cyc(1'b1, e == 1 || e == 33, 1'($urandom_range(0, 1)));
      cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    gap_chk = 0;
    check("halfrate_sync_err", {31'd0, sync_err}, 32'd0);

    // Misplaced frame_start at enable 20: error, partial dropped, addr 0 after enable 40.
    do_reset();
    for (int e = 1; e <= 48; e++) begin
      cyc(1'b1, e == 1 || e == 20, 1'($urandom_range(0, 1)));
      if (e == 19) check("early_sync_err", {31'd0, sync_err}, 32'd0);
      if (e == 20) check("misplaced_sync_err", {31'd0, sync_err}, 32'd1);
    end
    check("sticky_sync_err", {31'd0, sync_err}, {31'd0, m_err});

    // Missing frame_start at P=19 flags error but keeps running.
    do_reset();
    for (int e = 1; e <= 48; e++) begin
      cyc(1'b1, e == 1, 1'($urandom_range(0, 1)));
      if (e == 32) check("free_sync_err_pre", {31'd0, sync_err}, 32'd0);
      if (e == 33) check("free_sync_err", {31'd0, sync_err}, 32'd1);
    end

    // Reset while a write strobe is up clears outputs immediately.
    do_reset();
    for (int e = 1; e <= 21; e++) cyc(1'b1, e == 1, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_wr_en", {31'd0, wr_en}, 32'd0);
    check("async_wr_data", {24'd0, wr_data}, 32'd0);
    check("async_frame_done", {31'd0, frame_done}, 32'd0);
    do_reset();
    for (int e = 1; e <= 19; e++) cyc(1'b1, 1'b0, 1'b1);
    for (int e = 1; e <= 17; e++) cyc(1'b1, e == 1, 1'b1);
    do_reset();
    check("midword_wr_data", {24'd0, wr_data}, 32'd0);
    for (int e = 1; e <= 22; e++) cyc(1'b1, e == 1, 1'($urandom_range(0, 1)));
    check("final_sync_err", {31'd0, sync_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
